uart_rx: RTL and testbench

//   UART receiver: 8N1 serial -> parallel byte. LSB first, one start bit, no parity, one stop bit.

---
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (LSB first, one start bit, no parity, one stop bit).
// Ports:
//   iclk           system clock, rising edge
//   i_Rst          synchronous reset, active-high
//   i_RX_Serial    asynchronous serial line, idles high
//   o_RX_DV        one-cycle pulse, o_RX_Byte holds a freshly received byte
//   o_RX_Byte      last good byte, held until the next good byte
//   o_RX_Frame_Err one-cycle pulse, stop bit sampled low
//   o_RX_Active    high while a frame is in progress
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic       iclk,
    input  logic       i_Rst,
    input  logic       i_RX_Serial,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    output logic       o_RX_Frame_Err,
    output logic       o_RX_Active
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic             rx_meta;
    logic             rx_s;
    logic [2:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [2:0]       idx_q,    idx_d;
    logic [7:0]       shift_q,  shift_d;
    logic [7:0]       byte_q,   byte_d;
    logic             dv_q,     dv_d;
    logic             ferr_q,   ferr_d;
    logic             active_q, active_d;

    // Two-flop synchroniser; reset to the idle (high) line level
    always_ff @(posedge iclk) begin
        if (i_Rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_RX_Serial;
            rx_s    <= rx_meta;
        end
    end

    // State and registered outputs
    always_ff @(posedge iclk) begin
        if (i_Rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            dv_q     <= 1'b0;
            ferr_q   <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            ferr_q   <= ferr_d;
            active_q <= active_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        dv_d     = 1'b0;
        ferr_d   = 1'b0;
        active_d = active_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d  = S_START;
                    active_d = 1'b1;
                end
            end
            // Re-check the start bit at its centre to reject short glitches
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d  = S_IDLE;
                        active_d = 1'b0;
                    end
                end
            end
            // Start-bit centre is the phase reference, so a full bit later is a data centre
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    active_d = 1'b0;
                    if (rx_s) begin
                        byte_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end
            end
            // Held-low line: wait quietly for the line to return high
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                active_d = 1'b0;
            end
        endcase
    end

    assign o_RX_DV        = dv_q;
    assign o_RX_Byte      = byte_q;
    assign o_RX_Frame_Err = ferr_q;
    assign o_RX_Active    = active_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx at CLKS_PER_BIT=8.
module tb_uart_rx;

    localparam int unsigned CPB = 8;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    logic       iclk;
    logic       i_Rst;
    logic       i_RX_Serial;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic       o_RX_Frame_Err;
    logic       o_RX_Active;

    int   checks;
    int   failures;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [7:0] last_good;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .iclk          (iclk),
        .i_Rst         (i_Rst),
        .i_RX_Serial   (i_RX_Serial),
        .o_RX_DV       (o_RX_DV),
        .o_RX_Byte     (o_RX_Byte),
        .o_RX_Frame_Err(o_RX_Frame_Err),
        .o_RX_Active   (o_RX_Active)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // Watchdog so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: every output pulse must match the head of the scoreboard
    always @(negedge iclk) begin
        if (o_RX_DV || o_RX_Frame_Err) begin
            checks++;
            if (o_RX_DV && o_RX_Frame_Err) begin
                failures++;
                $display("FAIL flag_excl: dv=%0b ferr=%0b required not both", o_RX_DV, o_RX_Frame_Err);
            end else if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse: dv=%0b ferr=%0b byte=%02h required no pulse",
                         o_RX_DV, o_RX_Frame_Err, o_RX_Byte);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.is_err != o_RX_Frame_Err || o_RX_Byte !== mon_e.data) begin
                    failures++;
                    $display("FAIL pulse_match: got ferr=%0b byte=%02h required ferr=%0b byte=%02h",
                             o_RX_Frame_Err, o_RX_Byte, mon_e.is_err, mon_e.data);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, got, want);
        end
    endtask

    task automatic bit_time(input logic v);
        i_RX_Serial = v;
        repeat (CPB) @(negedge iclk);
    endtask

    // Reference model: a good stop bit yields DV with the data, a bad one yields
    // an error pulse with the previously received good byte still on the bus.
    task automatic send_frame(input logic [7:0] data, input logic stop);
        exp_t e;
        e.is_err = !stop;
        e.data   = stop ? data : last_good;
        if (stop) last_good = data;
        exp_q.push_back(e);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(data[i]);
        bit_time(stop);
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) bit_time(1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dv"},     32'(o_RX_DV),        32'd0);
        check({tag, "_ferr"},   32'(o_RX_Frame_Err), 32'd0);
        check({tag, "_active"}, 32'(o_RX_Active),    32'd0);
        check({tag, "_byte"},   32'(o_RX_Byte),      32'd0);
    endtask

    initial begin
        bit seen_active;
        logic [7:0] rb;
        logic       rs;
        checks      = 0;
        failures    = 0;
        last_good   = 8'h00;
        i_Rst       = 1'b1;
        i_RX_Serial = 1'b1;
        repeat (4) @(negedge iclk);
        check_reset_outputs("reset");
        i_Rst = 1'b0;
        idle_bits(2);

        // Single frame
        send_frame(8'hA5, 1'b1);
        idle_bits(2);

        // Back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h5A, 1'b1);
        idle_bits(2);

        // Short glitch: Active must pulse and fall with no flags
        seen_active = 1'b0;
        i_RX_Serial = 1'b0;
        repeat (2) @(negedge iclk);
        i_RX_Serial = 1'b1;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge iclk);
            if (o_RX_Active) seen_active = 1'b1;
        end
        check("glitch_active_seen", 32'(seen_active), 32'd1);
        check("glitch_active_low",  32'(o_RX_Active),  32'd0);
        send_frame(8'h3C, 1'b1);
        idle_bits(2);

        // Bad stop bit, then line high
        send_frame(8'h81, 1'b0);
        idle_bits(2);
        check("ferr_byte_held", 32'(o_RX_Byte), 32'h3C);

        // Break: 30 bit times low gives a single error pulse
        begin
            exp_t e;
            e.is_err = 1'b1;
            e.data   = last_good;
            exp_q.push_back(e);
        end
        for (int i = 0; i < 30; i++) bit_time(1'b0);
        check("break_active", 32'(o_RX_Active), 32'd0);
        idle_bits(2);
        send_frame(8'h42, 1'b1);
        idle_bits(2);

        // Reset during data bit 4 of 0xC3: frame aborted, no pulse
        rb = 8'hC3;
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(rb[i]);
        i_RX_Serial = rb[4];
        repeat (CPB / 2) @(negedge iclk);
        check("midframe_active", 32'(o_RX_Active), 32'd1);
        i_Rst       = 1'b1;
        i_RX_Serial = 1'b1;
        @(negedge iclk);
        check_reset_outputs("midreset");
        @(negedge iclk);
        i_Rst     = 1'b0;
        last_good = 8'h00;
        idle_bits(2);
        send_frame(8'h18, 1'b1);
        idle_bits(1);

        // Randomized frames with occasional bad stop bits and random gaps
        for (int n = 0; n < 24; n++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(0, 4) != 0);
            send_frame(rb, rs);
            if (!rs) idle_bits(1 + int'($urandom_range(0, 1)));
            else     idle_bits(int'($urandom_range(0, 2)));
        end
        idle_bits(2);

        // Drain the scoreboard under a bounded wait
        for (int i = 0; i < 20 * CPB && exp_q.size() != 0; i++) @(negedge iclk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("final_active", 32'(o_RX_Active), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
